capture_ring_buffer: RTL and testbench
======================================

Name: capture_ring_buffer

Overview:
- Multi-channel circular sample buffer for the ADC/HSMC acquisition path; generalises the single-channel write buffer.
- Records continuously while armed. On TRIGGER it freezes a window of DEPTH samples: PRE_LEN samples before the trigger, the trigger sample itself, and the samples after it.
- The frozen record is drained in order over a valid/ready stream toward the event-processing logic.

Parameters:
- NUM_CH, 2, number of ADC channels captured in lockstep.
- DWIDTH, 14, bits per channel sample.
- DEPTH, 16, record length in samples; must be a power of two and >= 4.
- ADDR_BITS, $clog2(DEPTH), buffer address width.
- CNT_BITS, 16, width of the missed-trigger counter.

Ports:
- CLOCK  in  1  single system clock; all logic is on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- ENABLE  in  1  sample strobe; DATA_IN is valid on cycles where ENABLE=1.
- DATA_IN  in  NUM_CH*DWIDTH  packed samples; channel k occupies bits [k*DWIDTH +: DWIDTH].
- ARM  in  1  single-cycle pulse; starts a new acquisition and latches PRE_LEN.
- PRE_LEN  in  ADDR_BITS  number of pre-trigger samples, 0..DEPTH-1.
- TRIGGER  in  1  event flag; honoured only when ENABLE=1 in the same cycle.
- DATA_OUT  out  NUM_CH*DWIDTH  readout sample.
- OUT_VALID  out  1  DATA_OUT holds a valid record sample.
- OUT_READY  in  1  consumer accepts the sample.
- OUT_LAST  out  1  asserted with the final (DEPTH-th) sample of the record.
- ARMED  out  1  state is FILL or WAIT_TRIG.
- BUSY  out  1  state is POST or READOUT.
- MISSED_TRIG  out  CNT_BITS  saturating count of triggers that were not honoured.

Behaviour:
- Reset (asynchronous, RESET=0):
  - State goes to IDLE; write and read pointers, fill counter and MISSED_TRIG clear to 0.
  - OUT_VALID, OUT_LAST, ARMED and BUSY go to 0; DATA_OUT goes to 0.
  - Buffer memory contents are not cleared.
  - Reset mid-readout abandons the record and requires no handshake.
- States: IDLE, FILL, WAIT_TRIG, POST, READOUT.
- IDLE:
  - ARM=1 latches PRE_LEN into pre_q, clears the fill counter and moves to FILL.
  - ENABLE samples are not written.
- FILL:
  - Each ENABLE writes DATA_IN at wr_ptr, then wr_ptr advances by 1 mod DEPTH and fill increments.
  - When fill reaches pre_q, move to WAIT_TRIG; with pre_q=0 this happens on the cycle after ARM.
  - TRIGGER while in FILL is ignored and increments MISSED_TRIG.
- WAIT_TRIG:
  - Writes continue and wrap freely.
  - On ENABLE=1 and TRIGGER=1, the current sample is written as the trigger sample.
  - At that point rd_ptr := wr_ptr - pre_q (mod DEPTH) and post_cnt := DEPTH-1-pre_q; move to POST, or straight to READOUT if post_cnt=0.
- POST:
  - Each ENABLE writes a sample and decrements post_cnt.
  - The write that brings post_cnt to 0 is the last write; move to READOUT.
  - TRIGGER increments MISSED_TRIG.
- READOUT:
  - No writes. Samples are read from rd_ptr, rd_ptr+1, …, wrapping mod DEPTH; exactly DEPTH samples are delivered.
  - Sample at record index PRE_LEN is the trigger sample.
  - First OUT_VALID rises 2 cycles after READOUT is entered (registered memory read plus output register).
  - Throughput is 1 sample per cycle while OUT_READY=1, with no bubbles after the first sample.
  - Stall rule: while OUT_VALID=1 and OUT_READY=0, DATA_OUT, OUT_LAST and OUT_VALID hold stable.
  - A transfer occurs when OUT_VALID and OUT_READY are both 1.
  - After the OUT_LAST transfer, go to IDLE; OUT_VALID drops on the next cycle.
  - TRIGGER increments MISSED_TRIG.
- ARM outside IDLE is ignored, and PRE_LEN is not re-latched.
- MISSED_TRIG saturates at 2^CNT_BITS-1 and clears only on reset.
- If TRIGGER and the cycle that completes FILL coincide, the trigger is missed; WAIT_TRIG is entered on the next cycle.
- Pointer arithmetic is modulo DEPTH via natural ADDR_BITS wrap.

Decomposition:
- Package capture_ring_buffer_pkg:
  - state enum (IDLE, FILL, WAIT_TRIG, POST, READOUT);
  - localparam for the sample word width NUM_CH*DWIDTH;
  - helper function for pointer subtraction mod DEPTH.
- Sub-module ring_ram:
  - simple dual-port RAM, DEPTH x (NUM_CH*DWIDTH);
  - synchronous write, registered read, read enable for stall;
  - no reset on the array, so it infers block RAM.
- Top level holds the FSM, pointers, counters and the output/skid register.

Test Plan (DEPTH=16, NUM_CH=2, DWIDTH=14, ch0 = sample index n, ch1 = 0x3FFF-n):
- Mid-window trigger:
  - Stimulus: ARM with PRE_LEN=4; ENABLE every cycle; TRIGGER on n=20; OUT_READY=1.
  - Required: 16 outputs with ch0 = 16..31; ch1 = 0x3FFF-16..0x3FFF-31; the sample with ch0=20 is at record index 4; OUT_LAST on ch0=31.
- Zero pre-trigger:
  - Stimulus: PRE_LEN=0; TRIGGER on n=3.
  - Required: ch0 = 3..18, and OUT_LAST on 18.
- Maximum pre-trigger:
  - Stimulus: PRE_LEN=15; trigger on n=40.
  - Required: no POST state; ch0 = 25..40; OUT_LAST on 40.
- Early trigger:
  - Stimulus: PRE_LEN=8; TRIGGER on n=2 (during FILL), then on n=12.
  - Required: MISSED_TRIG=1; record ch0 = 4..19.
- Backpressure:
  - Stimulus: during readout, OUT_READY toggles 1,0,0,1 repeating.
  - Required: DATA_OUT and OUT_VALID stable in stall cycles; full ordered record delivered with no duplicates.
- Reset mid-READOUT:
  - Stimulus: RESET asserted after 5 transfers.
  - Required: OUT_VALID=0 immediately, no clock needed; IDLE; a new ARM gives a correct fresh record.

Source files
------------

// File: rtl/capture_ring_buffer_pkg.sv
// Shared types, default sizing and pointer helper for the multi-channel capture ring buffer.
package capture_ring_buffer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FILL      = 3'd1,
      ST_WAIT_TRIG = 3'd2,
      ST_POST      = 3'd3,
      ST_READOUT   = 3'd4
   } state_e;

   localparam int unsigned DEF_NUM_CH = 2;
   localparam int unsigned DEF_DWIDTH = 14;
   localparam int unsigned SAMPLE_W   = DEF_NUM_CH * DEF_DWIDTH;

   // Depth is a power of two, so masking gives the modulo.
   function automatic int unsigned ptr_sub(input int unsigned a, input int unsigned b,
                                           input int unsigned depth);
      return (a - b) & (depth - 1);
   endfunction

endpackage

// File: rtl/capture_ring_buffer_ring_ram.sv
// Simple dual-port sample store: synchronous write, registered read with enable so a stalled
// reader keeps its last word. The array has no reset so it maps onto block RAM.
module capture_ring_buffer_ring_ram #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned W     = 28,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/capture_ring_buffer.sv
// Triggered multi-channel capture: records while armed, freezes a DEPTH-sample window around
// the trigger, then drains it in order over a valid/ready stream.
module capture_ring_buffer
   import capture_ring_buffer_pkg::*;
#(
   parameter int unsigned NUM_CH    = DEF_NUM_CH,
   parameter int unsigned DWIDTH    = DEF_DWIDTH,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned ADDR_BITS = $clog2(DEPTH),
   parameter int unsigned CNT_BITS  = 16
) (
   input  logic                     CLOCK,
   input  logic                     RESET,
   input  logic                     ENABLE,
   input  logic [NUM_CH*DWIDTH-1:0] DATA_IN,
   input  logic                     ARM,
   input  logic [ADDR_BITS-1:0]     PRE_LEN,
   input  logic                     TRIGGER,
   output logic [NUM_CH*DWIDTH-1:0] DATA_OUT,
   output logic                     OUT_VALID,
   input  logic                     OUT_READY,
   output logic                     OUT_LAST,
   output logic                     ARMED,
   output logic                     BUSY,
   output logic [CNT_BITS-1:0]      MISSED_TRIG,
   output state_e                   DBG_STATE
);

   // Stream contract: a sample moves when OUT_VALID and OUT_READY are both high on a rising
   // edge; while OUT_VALID=1 and OUT_READY=0, DATA_OUT, OUT_LAST and OUT_VALID hold.

   localparam int unsigned SW = NUM_CH * DWIDTH;
   localparam logic [ADDR_BITS-1:0] PRE_MAX  = ADDR_BITS'(DEPTH - 1);
   localparam logic [ADDR_BITS:0]   LAST_IDX = (ADDR_BITS+1)'(DEPTH - 1);

   state_e                state_q;
   logic [ADDR_BITS-1:0]  wr_ptr_q, rd_ptr_q, fill_q, pre_q, post_cnt_q;
   logic [ADDR_BITS:0]    rd_cnt_q;
   logic                  s1_valid_q, s1_last_q;
   logic                  out_valid_q, out_last_q, armed_q, busy_q;
   logic [SW-1:0]         dout_q;
   logic [CNT_BITS-1:0]   missed_q;

   logic                  wr_en, trig_hit, trig_miss, adv, issue, fill_done;
   logic [ADDR_BITS-1:0]  fill_inc;
   logic [SW-1:0]         rdata;

   always_comb begin
      wr_en     = ENABLE && (state_q == ST_FILL || state_q == ST_WAIT_TRIG ||
                             state_q == ST_POST);
      trig_hit  = ENABLE && TRIGGER && (state_q == ST_WAIT_TRIG);
      trig_miss = TRIGGER && (state_q == ST_FILL || state_q == ST_POST ||
                              state_q == ST_READOUT);
      adv       = !out_valid_q || OUT_READY;
      issue     = (state_q == ST_READOUT) && adv && !rd_cnt_q[ADDR_BITS];
      fill_inc  = fill_q + ADDR_BITS'(1);
      fill_done = (fill_q == pre_q) || (ENABLE && fill_inc == pre_q);
   end

   capture_ring_buffer_ring_ram #(
      .DEPTH (DEPTH),
      .W     (SW),
      .AW    (ADDR_BITS)
   ) u_ram (
      .clk_i   (CLOCK),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q),
      .wdata_i (DATA_IN),
      .re_i    (issue),
      .raddr_i (rd_ptr_q),
      .rdata_o (rdata)
   );

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fill_q      <= '0;
         pre_q       <= '0;
         post_cnt_q  <= '0;
         rd_cnt_q    <= '0;
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         armed_q     <= 1'b0;
         busy_q      <= 1'b0;
         dout_q      <= '0;
         missed_q    <= '0;
      end else begin
         if (trig_miss && missed_q != '1) missed_q <= missed_q + CNT_BITS'(1);
         if (wr_en) wr_ptr_q <= wr_ptr_q + ADDR_BITS'(1);

         case (state_q)
            ST_IDLE: begin
               if (ARM) begin
                  pre_q   <= PRE_LEN;
                  fill_q  <= '0;
                  armed_q <= 1'b1;
                  state_q <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (ENABLE) fill_q <= fill_inc;
               if (fill_done) state_q <= ST_WAIT_TRIG;
            end
            ST_WAIT_TRIG: begin
               // wr_ptr_q still addresses the trigger sample being written this cycle.
               if (trig_hit) begin
                  rd_ptr_q   <= ADDR_BITS'(ptr_sub(32'(wr_ptr_q), 32'(pre_q), DEPTH));
                  post_cnt_q <= PRE_MAX - pre_q;
                  rd_cnt_q   <= '0;
                  armed_q    <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= (pre_q == PRE_MAX) ? ST_READOUT : ST_POST;
               end
            end
            ST_POST: begin
               if (ENABLE) begin
                  post_cnt_q <= post_cnt_q - ADDR_BITS'(1);
                  if (post_cnt_q == ADDR_BITS'(1)) state_q <= ST_READOUT;
               end
            end
            ST_READOUT: begin
               if (issue) begin
                  rd_ptr_q <= rd_ptr_q + ADDR_BITS'(1);
                  rd_cnt_q <= rd_cnt_q + (ADDR_BITS+1)'(1);
               end
               // Read stage and output stage advance together, so a stall freezes both.
               if (adv) begin
                  s1_valid_q  <= issue;
                  s1_last_q   <= issue && (rd_cnt_q == LAST_IDX);
                  out_valid_q <= s1_valid_q;
                  out_last_q  <= s1_last_q;
                  if (s1_valid_q) dout_q <= rdata;
               end
               if (out_valid_q && OUT_READY && out_last_q) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  s1_valid_q  <= 1'b0;
                  s1_last_q   <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign DATA_OUT    = dout_q;
   assign OUT_VALID   = out_valid_q;
   assign OUT_LAST    = out_last_q;
   assign ARMED       = armed_q;
   assign BUSY        = busy_q;
   assign MISSED_TRIG = missed_q;
   assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_capture_ring_buffer.sv
// Directed bench for capture_ring_buffer: expected records are queued by the driver and
// popped by an independent monitor on every accepted output sample.
module tb_capture_ring_buffer;
   import capture_ring_buffer_pkg::*;

   localparam int SW = 28;
   localparam int AB = 4;
   localparam int CB = 16;

   logic          CLOCK = 1'b0;
   logic          RESET, ENABLE, ARM, TRIGGER, OUT_READY;
   logic [SW-1:0] DATA_IN, DATA_OUT;
   logic [AB-1:0] PRE_LEN;
   logic          OUT_VALID, OUT_LAST, ARMED, BUSY;
   logic [CB-1:0] MISSED_TRIG;
   state_e        dbg_state;

   logic [SW:0]   exp_q[$];
   int            n_cmp = 0;
   int            n_fail = 0;
   int            n_xfer = 0;
   int            exp_missed = 0;
   int            ready_mode = 0;
   bit            saw_post = 0;

   capture_ring_buffer dut (
      .CLOCK       (CLOCK),
      .RESET       (RESET),
      .ENABLE      (ENABLE),
      .DATA_IN     (DATA_IN),
      .ARM         (ARM),
      .PRE_LEN     (PRE_LEN),
      .TRIGGER     (TRIGGER),
      .DATA_OUT    (DATA_OUT),
      .OUT_VALID   (OUT_VALID),
      .OUT_READY   (OUT_READY),
      .OUT_LAST    (OUT_LAST),
      .ARMED       (ARMED),
      .BUSY        (BUSY),
      .MISSED_TRIG (MISSED_TRIG),
      .DBG_STATE   (dbg_state)
   );

   // clock / reset
   always #5 CLOCK = ~CLOCK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [SW-1:0] sample(input int n);
      logic [13:0] c0, c1;
      c0 = 14'(n);
      c1 = 14'h3FFF - c0;
      return {c1, c0};
   endfunction

   // ready driver: mode 0 always ready, mode 1 repeats 1,0,0,1
   initial begin
      int rp;
      rp = 0;
      OUT_READY = 1'b1;
      forever begin
         @(posedge CLOCK); #1;
         if (ready_mode == 0) OUT_READY = 1'b1;
         else begin
            OUT_READY = (rp % 4 == 0) || (rp % 4 == 3);
            rp++;
         end
      end
   end

   // monitor / scoreboard
   logic [SW-1:0] held_data;
   logic          held_last;
   bit            stalled = 0;

   always @(negedge CLOCK) begin
      if (!RESET) stalled = 0;
      else begin
         if (dbg_state == ST_POST) saw_post = 1;
         if (stalled) begin
            check("stall_valid", 64'(OUT_VALID), 64'd1);
            check("stall_data", 64'(DATA_OUT), 64'(held_data));
            check("stall_last", 64'(OUT_LAST), 64'(held_last));
         end
         if (OUT_VALID && OUT_READY) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_out: got %0h, expected no output at %0t", DATA_OUT, $time);
            end else begin
               logic [SW:0] e;
               e = exp_q.pop_front();
               check("rec_data", 64'(DATA_OUT), 64'(e[SW-1:0]));
               check("rec_last", 64'(OUT_LAST), 64'(e[SW]));
            end
            n_xfer++;
            stalled = 0;
         end else if (OUT_VALID) begin
            stalled   = 1;
            held_data = DATA_OUT;
            held_last = OUT_LAST;
         end else begin
            stalled = 0;
         end
      end
   end

   // driver tasks
   task automatic arm(input logic [AB-1:0] pre);
      @(posedge CLOCK); #1;
      ARM = 1'b1; PRE_LEN = pre; ENABLE = 1'b0; TRIGGER = 1'b0;
      @(posedge CLOCK); #1;
      ARM = 1'b0;
   endtask

   task automatic push_record(input int first);
      for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), sample(first + i)});
   endtask

   task automatic stream(input int n_samples, input int trig_a, input int trig_b);
      for (int n = 0; n < n_samples; n++) begin
         ENABLE  = 1'b1;
         DATA_IN = sample(n);
         TRIGGER = (n == trig_a) || (n == trig_b);
         @(posedge CLOCK); #1;
      end
      ENABLE = 1'b0; TRIGGER = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit done;
      done = 0;
      for (int c = 0; c < 400 && !done; c++) begin
         @(negedge CLOCK); #1;
         if (dbg_state == ST_IDLE && !OUT_VALID && exp_q.size() == 0) done = 1;
      end
      check({name, "_done"}, 64'(done), 64'd1);
      exp_q.delete();
   endtask

   task automatic run_test(input string name, input logic [AB-1:0] pre, input int trig_a,
                           input int trig_b, input int first);
      arm(pre);
      check({name, "_armed"}, 64'(ARMED), 64'd1);
      check({name, "_busy0"}, 64'(BUSY), 64'd0);
      push_record(first);
      stream(trig_a + 15 - int'(pre) + 3, trig_a, trig_b);
      wait_done(name);
      check({name, "_missed"}, 64'(MISSED_TRIG), 64'(exp_missed));
      check({name, "_idle_armed"}, 64'(ARMED), 64'd0);
      check({name, "_idle_busy"}, 64'(BUSY), 64'd0);
   endtask

   initial begin
      int base;
      bit ok;
      RESET = 1'b0; ENABLE = 1'b0; ARM = 1'b0; TRIGGER = 1'b0;
      PRE_LEN = '0; DATA_IN = '0;
      #12;
      check("rst_valid", 64'(OUT_VALID), 64'd0);
      check("rst_last", 64'(OUT_LAST), 64'd0);
      check("rst_armed", 64'(ARMED), 64'd0);
      check("rst_busy", 64'(BUSY), 64'd0);
      check("rst_data", 64'(DATA_OUT), 64'd0);
      check("rst_missed", 64'(MISSED_TRIG), 64'd0);
      check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
      @(negedge CLOCK); #1;
      RESET = 1'b1;

      saw_post = 0;
      run_test("mid", 4'd4, 20, -1, 16);
      check("mid_post_seen", 64'(saw_post), 64'd1);

      run_test("zero_pre", 4'd0, 3, -1, 3);

      saw_post = 0;
      run_test("max_pre", 4'd15, 40, -1, 25);
      check("max_pre_no_post", 64'(saw_post), 64'd0);

      exp_missed = 1;
      run_test("early", 4'd8, 12, 2, 4);

      ready_mode = 1;
      run_test("backpressure", 4'd4, 20, -1, 16);
      ready_mode = 0;

      // reset in the middle of a readout
      arm(4'd4);
      push_record(16);
      base = n_xfer;
      stream(33, 20, -1);
      ok = 0;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(negedge CLOCK); #1;
         if (n_xfer >= base + 5) ok = 1;
      end
      check("rst_mid_reached", 64'(ok), 64'd1);
      RESET = 1'b0;
      #1;
      check("rst_mid_valid", 64'(OUT_VALID), 64'd0);
      check("rst_mid_state", 64'(dbg_state), 64'(ST_IDLE));
      check("rst_mid_busy", 64'(BUSY), 64'd0);
      check("rst_mid_missed", 64'(MISSED_TRIG), 64'd0);
      exp_q.delete();
      exp_missed = 0;
      @(negedge CLOCK); #1;
      RESET = 1'b1;

      run_test("fresh", 4'd6, 9, -1, 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
